// File: rtl/reduce_pkg.sv
// Shared types and helpers for the sequential N-bit reduction unit.
// Modes select the base operator; NAND reuses AND and inverts only at the output.
package reduce_pkg;

    typedef enum logic [1:0] {
        RED_AND  = 2'b00,
        RED_OR   = 2'b01,
        RED_XOR  = 2'b10,
        RED_NAND = 2'b11
    } reduce_mode_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DONE = 2'b10
    } reduce_state_t;

    // The identity value leaves the first chunk result unchanged when it is folded in.
    function automatic logic acc_identity(input reduce_mode_t mode);
        return (mode == RED_AND) || (mode == RED_NAND);
    endfunction

    function automatic logic acc_fold(input reduce_mode_t mode, input logic acc, input logic red);
        logic res;
        case (mode)
            RED_OR:  res = acc | red;
            RED_XOR: res = acc ^ red;
            default: res = acc & red;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/reduce_chunk.sv
// Combinational reduction of one CHUNK_WIDTH-bit slice.
// Each operator is a linear gate chain, bit 0 first, like the original N-bit AND.
module reduce_chunk
    import reduce_pkg::*;
#(
    parameter int CHUNK_WIDTH = 16
) (
    input  logic [CHUNK_WIDTH-1:0] chunk_i,
    input  reduce_mode_t           mode_i,
    output logic                   red_o
);

    logic and_chain;
    logic or_chain;
    logic xor_chain;

    always_comb begin
        and_chain = chunk_i[0];
        or_chain  = chunk_i[0];
        xor_chain = chunk_i[0];
        for (int i = 1; i < CHUNK_WIDTH; i++) begin
            and_chain = and_chain & chunk_i[i];
            or_chain  = or_chain  | chunk_i[i];
            xor_chain = xor_chain ^ chunk_i[i];
        end
    end

    always_comb begin
        case (mode_i)
            RED_OR:  red_o = or_chain;
            RED_XOR: red_o = xor_chain;
            default: red_o = and_chain;
        endcase
    end

endmodule

// File: rtl/reduce_n_seq.sv
// Multi-cycle N-bit reduction: folds CHUNK_WIDTH bits per cycle, LSB chunk first,
// into a one-bit accumulator, with valid/ready handshakes on both sides.
module reduce_n_seq
    import reduce_pkg::*;
#(
    parameter int GATE_WIDTH  = 64,
    parameter int CHUNK_WIDTH = 16
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  in_valid_i,
    output logic                  in_ready_o,
    input  logic [GATE_WIDTH-1:0] in_i,
    input  logic [1:0]            mode_i,
    output logic                  out_valid_o,
    input  logic                  out_ready_i,
    output logic                  out_o
);

    localparam int NUM_CHUNKS = GATE_WIDTH / CHUNK_WIDTH;
    localparam int CNT_W      = (NUM_CHUNKS > 1) ? $clog2(NUM_CHUNKS) : 1;
    localparam logic [CNT_W-1:0] LAST_CHUNK = CNT_W'(NUM_CHUNKS - 1);

    if (GATE_WIDTH < 1 || CHUNK_WIDTH < 1 || (GATE_WIDTH % CHUNK_WIDTH) != 0) begin : g_bad_cfg
        $fatal(1, "reduce_n_seq: CHUNK_WIDTH must divide GATE_WIDTH");
    end

    reduce_state_t         state_q, state_d;
    logic [GATE_WIDTH-1:0] op_q, op_d;
    reduce_mode_t          mode_q, mode_d;
    logic                  acc_q, acc_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  in_ready_q, in_ready_d;

    logic                  chunk_red;
    logic [GATE_WIDTH-1:0] op_shift;

    // With a single chunk there is nothing left to shift in after the fold.
    if (NUM_CHUNKS == 1) begin : g_shift_one
        assign op_shift = '0;
    end else begin : g_shift_many
        assign op_shift = {{CHUNK_WIDTH{1'b0}}, op_q[GATE_WIDTH-1:CHUNK_WIDTH]};
    end

    reduce_chunk #(
        .CHUNK_WIDTH(CHUNK_WIDTH)
    ) u_chunk (
        .chunk_i(op_q[CHUNK_WIDTH-1:0]),
        .mode_i (mode_q),
        .red_o  (chunk_red)
    );

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        mode_d  = mode_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (in_valid_i && in_ready_q) begin
                    op_d    = in_i;
                    mode_d  = reduce_mode_t'(mode_i);
                    acc_d   = acc_identity(reduce_mode_t'(mode_i));
                    cnt_d   = '0;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                acc_d = acc_fold(mode_q, acc_q, chunk_red);
                op_d  = op_shift;
                if (cnt_q == LAST_CHUNK) begin
                    state_d = ST_DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_DONE: begin
                if (out_ready_i) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        in_ready_d = (state_d == ST_IDLE);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= ST_IDLE;
            op_q       <= '0;
            mode_q     <= RED_AND;
            acc_q      <= 1'b0;
            cnt_q      <= '0;
            in_ready_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            mode_q     <= mode_d;
            acc_q      <= acc_d;
            cnt_q      <= cnt_d;
            in_ready_q <= in_ready_d;
        end
    end

    // in_ready is registered so it stays low through the reset cycle itself.
    assign in_ready_o  = in_ready_q;
    assign out_valid_o = (state_q == ST_DONE);
    assign out_o       = acc_q ^ (mode_q == RED_NAND);

endmodule

// File: tb/tb_reduce_n_seq.sv
// Directed bench: 64/16 instance for the mode table and corner sequences,
// 64/64 instance for single-chunk latency and initiation interval.
module tb_reduce_n_seq;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic        rst;
    logic        a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_out;
    logic [63:0] a_in;
    logic [1:0]  a_mode;
    logic        b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_out;
    logic [63:0] b_in;
    logic [1:0]  b_mode;

    reduce_n_seq #(.GATE_WIDTH(64), .CHUNK_WIDTH(16)) u_a (
        .clk_i(clk), .rst_i(rst),
        .in_valid_i(a_in_valid), .in_ready_o(a_in_ready), .in_i(a_in), .mode_i(a_mode),
        .out_valid_o(a_out_valid), .out_ready_i(a_out_ready), .out_o(a_out)
    );

    reduce_n_seq #(.GATE_WIDTH(64), .CHUNK_WIDTH(64)) u_b (
        .clk_i(clk), .rst_i(rst),
        .in_valid_i(b_in_valid), .in_ready_o(b_in_ready), .in_i(b_in), .mode_i(b_mode),
        .out_valid_o(b_out_valid), .out_ready_i(b_out_ready), .out_o(b_out)
    );

    int pass_cnt  = 0;
    int total_cnt = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total_cnt++;
        if (act !== exp) $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        else pass_cnt++;
    endtask

    function automatic logic chunk_red(input logic [1:0] m, input logic [15:0] c);
        case (m)
            2'b01:   return |c;
            2'b10:   return ^c;
            default: return &c;
        endcase
    endfunction

    function automatic logic fold(input logic [1:0] m, input logic acc, input logic r);
        case (m)
            2'b01:   return acc | r;
            2'b10:   return acc ^ r;
            default: return acc & r;
        endcase
    endfunction

    typedef struct {
        logic [1:0]  mode;
        logic [63:0] data;
        logic        exp;
        string       name;
    } vec_t;

    vec_t vecs[8];

    // One full transaction on the 64/16 instance, checking latency and the
    // LSB-first accumulator trajectory against a bench-side model.
    task automatic run_a(input logic [1:0] m, input logic [63:0] d, input logic exp, input string name);
        int   n;
        logic macc;
        n = 0;
        while (!a_in_ready && n < 20) begin @(negedge clk); n++; end
        chk({name, " in_ready"}, a_in_ready, 1);
        a_mode = m; a_in = d; a_in_valid = 1'b1;
        @(negedge clk);
        a_in_valid = 1'b0; a_in = '0; a_mode = 2'b00;
        macc = (m == 2'b00) || (m == 2'b11);
        for (int k = 0; k < 4; k++) begin
            chk({name, " busy"}, {a_out_valid, a_in_ready}, 2'b00);
            @(negedge clk);
            macc = fold(m, macc, chunk_red(m, d[k*16 +: 16]));
            chk({name, " acc"}, u_a.acc_q, macc);
        end
        chk({name, " latency"}, a_out_valid, 1);
        n = 0;
        while (!a_out_valid && n < 20) begin @(negedge clk); n++; end
        chk({name, " out"}, a_out, exp);
        @(negedge clk);
        chk({name, " release"}, {a_out_valid, a_in_ready}, 2'b01);
        $display("txn %s mode=%0d in=%h out=%0d exp=%0d", name, m, d, a_out, exp);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        int   n;
        int   acc_cyc[$];
        vecs[0] = '{2'b00, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, "and_ones"};
        vecs[1] = '{2'b00, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, "and_lsb0"};
        vecs[2] = '{2'b01, 64'h0,                   1'b0, "or_zero"};
        vecs[3] = '{2'b01, 64'h8000_0000_0000_0000, 1'b1, "or_msb"};
        vecs[4] = '{2'b10, 64'h0000_0000_0000_0007, 1'b1, "xor_7"};
        vecs[5] = '{2'b10, 64'h0001_0000_0000_0001, 1'b0, "xor_2bits"};
        vecs[6] = '{2'b11, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, "nand_ones"};
        vecs[7] = '{2'b11, 64'h0,                   1'b1, "nand_zero"};

        rst = 1'b1;
        a_in_valid = 0; a_in = '0; a_mode = 0; a_out_ready = 1;
        b_in_valid = 0; b_in = '0; b_mode = 0; b_out_ready = 1;
        @(negedge clk); @(negedge clk);
        chk("reset a", {a_in_ready, a_out_valid, a_out}, 3'b000);
        chk("reset b", {b_in_ready, b_out_valid, b_out}, 3'b000);
        chk("reset acc", u_a.acc_q, 0);
        rst = 1'b0;
        @(negedge clk);
        chk("post-reset ready a", a_in_ready, 1);
        chk("post-reset ready b", b_in_ready, 1);

        foreach (vecs[i]) run_a(vecs[i].mode, vecs[i].data, vecs[i].exp, vecs[i].name);

        // Backpressure: result held while a new operand is offered and ignored.
        a_out_ready = 0;
        a_mode = 2'b00; a_in = 64'hFFFF_FFFF_FFFF_FFFF; a_in_valid = 1;
        @(negedge clk);
        a_in_valid = 0;
        n = 0;
        while (!a_out_valid && n < 20) begin @(negedge clk); n++; end
        chk("bp done", a_out_valid, 1);
        a_mode = 2'b01; a_in = 64'h0; a_in_valid = 1;
        for (int i = 0; i < 5; i++) begin
            chk("bp hold", {a_out_valid, a_out, a_in_ready}, 3'b110);
            @(negedge clk);
        end
        a_out_ready = 1;
        @(negedge clk);
        chk("bp release", {a_out_valid, a_in_ready}, 2'b01);
        @(negedge clk);
        a_in_valid = 0;
        chk("bp second accepted", a_in_ready, 0);
        n = 0;
        while (!a_out_valid && n < 20) begin @(negedge clk); n++; end
        chk("bp second result", {a_out_valid, a_out}, 2'b10);
        $display("txn backpressure second or_zero out=%0d", a_out);
        @(negedge clk);

        // Reset during the second RUN cycle discards the operand.
        a_mode = 2'b00; a_in = 64'hFFFF_FFFF_FFFF_FFFF; a_in_valid = 1;
        @(negedge clk);
        a_in_valid = 0;
        @(negedge clk);
        rst = 1;
        @(negedge clk);
        chk("midrun reset", {a_out_valid, a_in_ready}, 2'b00);
        rst = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("after reset", {a_out_valid, a_in_ready}, 2'b01);
        end
        $display("txn midrun reset discarded");
        run_a(2'b01, 64'h1, 1'b1, "or_one_after_reset");

        // Single-chunk configuration: latency of one cycle.
        b_mode = 2'b00; b_in = 64'hFFFF_FFFF_FFFF_FFFF; b_in_valid = 1;
        @(negedge clk);
        b_in_valid = 0;
        chk("b run", b_out_valid, 0);
        @(negedge clk);
        chk("b latency", {b_out_valid, b_out}, 2'b11);
        @(negedge clk);
        chk("b release", {b_out_valid, b_in_ready}, 2'b01);
        $display("txn b and_ones out=%0d", b_out);

        // Back-to-back with out_ready held high: acceptances every 3 cycles.
        b_in_valid = 1;
        for (int i = 0; i < 15; i++) begin
            if (b_in_valid && b_in_ready) acc_cyc.push_back(cyc);
            if (b_out_valid) chk("b2b out", b_out, 1);
            @(negedge clk);
        end
        b_in_valid = 0;
        chk("b2b count", acc_cyc.size() >= 4, 1);
        for (int i = 1; i < acc_cyc.size(); i++) begin
            chk("b2b interval", acc_cyc[i] - acc_cyc[i-1], 3);
            $display("txn b2b accept at cycle %0d interval %0d", acc_cyc[i], acc_cyc[i] - acc_cyc[i-1]);
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
